// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, S-boxes, decrypt rotation schedule,
// controller state encoding and the bit-permutation helpers built on them.
package des_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_FINAL = 2'd3
    } des_state_t;

    localparam int ROUND_W    = 5;
    localparam int NUM_ROUNDS = 16;

    // Right-rotation applied to C/D before round r (index r-1); K16 is used first.
    localparam int DEC_ROT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int IP_INV_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    localparam int E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    // Each box is row-major: entry [row*16 + col].
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [1:64] ip_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 1; i <= 64; i++) y[i] = x[IP_TBL[i-1]];
        return y;
    endfunction

    function automatic logic [1:64] ip_inv_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 1; i <= 64; i++) y[i] = x[IP_INV_TBL[i-1]];
        return y;
    endfunction

    function automatic logic [1:56] pc1_perm(input logic [1:64] x);
        logic [1:56] y;
        for (int i = 1; i <= 56; i++) y[i] = x[PC1_TBL[i-1]];
        return y;
    endfunction

    function automatic logic [1:48] pc2_perm(input logic [1:56] x);
        logic [1:48] y;
        for (int i = 1; i <= 48; i++) y[i] = x[PC2_TBL[i-1]];
        return y;
    endfunction

    function automatic logic [1:48] e_expand(input logic [1:32] x);
        logic [1:48] y;
        for (int i = 1; i <= 48; i++) y[i] = x[E_TBL[i-1]];
        return y;
    endfunction

    function automatic logic [1:32] p_perm(input logic [1:32] x);
        logic [1:32] y;
        for (int i = 1; i <= 32; i++) y[i] = x[P_TBL[i-1]];
        return y;
    endfunction

    // Outer bits pick the row, middle four the column.
    function automatic logic [3:0] sbox_lookup(input int s, input logic [1:6] b);
        return 4'(SBOX[s][{b[1], b[6], b[2:5]}]);
    endfunction

    function automatic logic [1:28] ror28(input logic [1:28] x, input int n);
        case (n)
            1:       return {x[28], x[1:27]};
            2:       return {x[27:28], x[1:26]};
            default: return x;
        endcase
    endfunction

    // 1 when any key byte has even parity (DES key bytes are odd parity).
    function automatic logic key_parity_bad(input logic [1:64] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) bad = bad | ~(^k[1+8*b +: 8]);
        return bad;
    endfunction

endpackage

// File: rtl/des_decrypt_controller_if.sv
// Start/ready bus of the DES decrypt controller; key_err exists only when
// DES_DEC_KEY_PARITY_EN is defined.
interface des_decrypt_controller_if;
    import des_pkg::*;

    // Handshake: the master raises start (rising edge only is acted on) with
    // desIn/keyIn valid on that same edge; the slave drops ready on acceptance
    // and raises it when desOut (and key_err) hold the completed result.
    // Edges arriving while busy are dropped, not queued.
    logic        start;
    logic [1:64] desIn;
    logic [1:64] keyIn;
    logic        ready;
    logic [1:64] desOut;
`ifdef DES_DEC_KEY_PARITY_EN
    logic        key_err;
`endif
    des_state_t  dbg_state;

    modport master (
        output start, desIn, keyIn,
        input  ready, desOut, dbg_state
`ifdef DES_DEC_KEY_PARITY_EN
        , input key_err
`endif
    );

    modport slave (
        input  start, desIn, keyIn,
        output ready, desOut, dbg_state
`ifdef DES_DEC_KEY_PARITY_EN
        , output key_err
`endif
    );

endinterface

// File: rtl/f_function_combinational.sv
// DES round function f(R, K): expansion, key mix, S-box substitution, P permutation.
module f_function_combinational
    import des_pkg::*;
(
    input  logic [1:32] r,
    input  logic [1:48] k,
    output logic [1:32] f
);

    logic [1:48] x;
    logic [1:32] s_out;

    always_comb begin
        x     = e_expand(r) ^ k;
        s_out = '0;
        for (int s = 0; s < 8; s++) s_out[1+4*s +: 4] = sbox_lookup(s, x[1+6*s +: 6]);
        f     = p_perm(s_out);
    end

endmodule

// File: rtl/des_decrypt_controller.sv
// Iterative single-DES decryptor, one round per clock, subkeys generated in
// reverse by right-rotating C/D. Optional key parity flag: DES_DEC_KEY_PARITY_EN.
module des_decrypt_controller
    import des_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    des_decrypt_controller_if.slave  bus
);

    des_state_t         state_q, state_d;
    logic               start_prev;
    logic               start_rise;
    logic [1:64]        ct_q, key_q;
    logic [1:32]        l_q, r_q;
    logic [1:28]        c_q, d_q;
    logic [ROUND_W-1:0] round_q;
    logic [1:64]        out_q;
    logic               ready_q;

    logic [3:0]         rnd_idx;
    logic [1:28]        c_rot, d_rot;
    logic [1:48]        round_key;
    logic [1:32]        f_out;

    assign start_rise = bus.start & ~start_prev;

    // round 16 is 5'b10000, so its low nibble minus one wraps to index 15.
    assign rnd_idx   = round_q[3:0] - 4'd1;
    assign c_rot     = ror28(c_q, DEC_ROT[rnd_idx]);
    assign d_rot     = ror28(d_q, DEC_ROT[rnd_idx]);
    assign round_key = pc2_perm({c_rot, d_rot});

    f_function_combinational u_f (
        .r (r_q),
        .k (round_key),
        .f (f_out)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_rise) state_d = S_LOAD;
            S_LOAD:  state_d = S_ROUND;
            S_ROUND: if (round_q == ROUND_W'(NUM_ROUNDS)) state_d = S_FINAL;
            S_FINAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef DES_DEC_KEY_PARITY_EN
    logic parity_bad_q;
    logic key_err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev <= 1'b0;
            ct_q       <= '0;
            key_q      <= '0;
            l_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            round_q    <= '0;
            out_q      <= '0;
            ready_q    <= 1'b0;
`ifdef DES_DEC_KEY_PARITY_EN
            parity_bad_q <= 1'b0;
            key_err_q    <= 1'b0;
`endif
        end else begin
            // Tracked in every state so a level held through completion never retriggers.
            start_prev <= bus.start;
            case (state_q)
                S_IDLE: begin
                    if (start_rise) begin
                        ct_q    <= bus.desIn;
                        key_q   <= bus.keyIn;
                        ready_q <= 1'b0;
`ifdef DES_DEC_KEY_PARITY_EN
                        parity_bad_q <= key_parity_bad(bus.keyIn);
                        key_err_q    <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    {l_q, r_q} <= ip_perm(ct_q);
                    {c_q, d_q} <= pc1_perm(key_q);
                    round_q    <= ROUND_W'(1);
                end
                S_ROUND: begin
                    c_q <= c_rot;
                    d_q <= d_rot;
                    l_q <= r_q;
                    r_q <= l_q ^ f_out;
                    if (round_q != ROUND_W'(NUM_ROUNDS)) round_q <= round_q + ROUND_W'(1);
                end
                S_FINAL: begin
                    out_q   <= ip_inv_perm({r_q, l_q});
                    ready_q <= 1'b1;
`ifdef DES_DEC_KEY_PARITY_EN
                    key_err_q <= parity_bad_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.desOut    = out_q;
    assign bus.dbg_state = state_q;
`ifdef DES_DEC_KEY_PARITY_EN
    assign bus.key_err   = key_err_q;
`endif

endmodule

// File: tb/tb_des_decrypt_controller.sv
// Bench for des_decrypt_controller: directed known-answer vectors, scoreboard
// queue consumed by a monitor on each rising ready.
module tb_des_decrypt_controller;
    import des_pkg::*;

    localparam int W = 65;  // {expected key_err, expected plaintext}

    localparam logic [63:0] V1_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] V1_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] V1_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] V2_CT  = 64'h8CA64DE9C1B123A7;
    localparam logic [63:0] V2_KEY = 64'h0101010101010101;
    localparam logic [63:0] V3_KEY = 64'h0000000000000000;
    localparam logic [63:0] ZERO64 = 64'h0;

    logic clk = 1'b0;
    logic rst;

    des_decrypt_controller_if bus ();

    des_decrypt_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset / counters
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_done    = 0;
    int start_cyc = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor
    logic         ready_prev = 1'b0;
    logic [W-1:0] exp_e;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.ready === 1'b1 && ready_prev !== 1'b1) begin
                n_done++;
                check("completion_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("plaintext", bus.desOut, exp_e[63:0]);
`ifdef DES_DEC_KEY_PARITY_EN
                    check("key_err", 64'(bus.key_err), 64'(exp_e[64]));
`endif
                    check("latency", 64'(cyc - start_cyc), 64'd18);
                end
            end
            ready_prev = bus.ready;
        end
    end

    // ---------------- driver tasks (called off the active edge)
    task automatic start_op(input logic [63:0] ct, input logic [63:0] key,
                            input logic [63:0] pt, input logic err);
        bus.desIn = ct;
        bus.keyIn = key;
        bus.start = 1'b1;
        exp_q.push_back({err, pt});
        start_cyc = cyc + 1;
    endtask

    task automatic wait_done(input int n_before, input string name);
        int k;
        k = 0;
        while (n_done == n_before && k < 60) begin
            @(posedge clk);
            #7;
            k++;
        end
        check(name, 64'(n_done - n_before), 64'd1);
    endtask

    task automatic run_pulse(input logic [63:0] ct, input logic [63:0] key,
                             input logic [63:0] pt, input logic err, input string name);
        int nb;
        @(posedge clk);
        #2;
        nb = n_done;
        start_op(ct, key, pt, err);
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        wait_done(nb, name);
    endtask

    // ---------------- stimulus
    initial begin
        int nb;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.desIn = '0;
        bus.keyIn = '0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 64'(bus.ready), 64'd0);
        check("reset_desOut", bus.desOut, ZERO64);
        check("reset_state", 64'(bus.dbg_state), 64'(S_IDLE));
`ifdef DES_DEC_KEY_PARITY_EN
        check("reset_key_err", 64'(bus.key_err), 64'd0);
`endif

        // Known-answer vectors
        run_pulse(V1_CT, V1_KEY, V1_PT, 1'b0, "v1_done");
        run_pulse(V2_CT, V2_KEY, ZERO64, 1'b0, "v2_done");
        run_pulse(V2_CT, V3_KEY, ZERO64, 1'b1, "v3_done");

        // Level held, inputs scrambled at round 5, extra edge at round 10
        @(posedge clk);
        #2;
        nb = n_done;
        start_op(V1_CT, V1_KEY, V1_PT, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        bus.desIn = {$urandom, $urandom};
        bus.keyIn = {$urandom, $urandom};
        repeat (4) @(posedge clk);
        #2;
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        bus.start = 1'b1;
        repeat (29) @(posedge clk);
        #2;
        bus.start = 1'b0;
        repeat (25) @(posedge clk);
        #2;
        check("held_start_one_completion", 64'(n_done - nb), 64'd1);

        // Reset at round 8 abandons the operation
        @(posedge clk);
        #2;
        nb = n_done;
        start_op(V1_CT, V1_KEY, V1_PT, 1'b0);
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_ready", 64'(bus.ready), 64'd0);
        check("abort_desOut", bus.desOut, ZERO64);
        check("abort_state", 64'(bus.dbg_state), 64'(S_IDLE));
        repeat (25) @(posedge clk);
        #2;
        check("abort_no_completion", 64'(n_done - nb), 64'd0);
        run_pulse(V1_CT, V1_KEY, V1_PT, 1'b0, "after_abort_done");

        // Back-to-back: second start on the edge right after ready rises
        run_pulse(V1_CT, V1_KEY, V1_PT, 1'b0, "b2b_first_done");
        nb = n_done;
        start_op(V2_CT, V2_KEY, ZERO64, 1'b0);
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("b2b_ready_low", 64'(bus.ready), 64'd0);
            check("b2b_desOut_hold", bus.desOut, V1_PT);
        end
        wait_done(nb, "b2b_second_done");

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
        $fatal(1, "watchdog");
    end

endmodule
